// File: rtl/sdram_byte_writer.sv
// Packs an SD byte stream into little-endian 16-bit words, buffers them in a small FIFO and
// issues open-loop paced writes to the SDRAM controller at consecutive word addresses.
module sdram_byte_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned REQ_HOLD   = 2,
    parameter int unsigned OP_CYCLES  = 10,
    parameter logic [7:0]  PAD_BYTE   = 8'hFF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [21:0] base_addr_i,
    input  logic [7:0]  byte_in_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    input  logic        flush_i,
    output logic        wr_req_o,
    output logic [21:0] wr_addr_o,
    output logic [15:0] wr_data_o,
    output logic        busy_o,
    output logic [21:0] word_count_o
);

    localparam int unsigned ADDR_W = 22;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned CNT_W  = $clog2(OP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    op_cnt_q, op_cnt_d;
    logic [7:0]          low_q, low_d;
    logic                have_low_q, have_low_d;
    logic                flush_pend_q, flush_pend_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [ADDR_W-1:0]   addr_ptr_q, addr_ptr_d;
    logic [ADDR_W-1:0]   word_count_q, word_count_d;
    logic                wr_req_q, wr_req_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                byte_ready_q, byte_ready_d;

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   push_data;
    logic                byte_acc;
    logic                fifo_full;

    assign byte_ready_o = byte_ready_q;
    assign wr_req_o     = wr_req_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign busy_o       = busy_q;
    assign word_count_o = word_count_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            op_cnt_q     <= '0;
            low_q        <= '0;
            have_low_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            addr_ptr_q   <= '0;
            word_count_q <= '0;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            byte_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_cnt_q     <= op_cnt_d;
            low_q        <= low_d;
            have_low_q   <= have_low_d;
            flush_pend_q <= flush_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            addr_ptr_q   <= addr_ptr_d;
            word_count_q <= word_count_d;
            wr_req_q     <= wr_req_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            byte_ready_q <= byte_ready_d;
        end
    end

    // FIFO storage; stale entries after reset are harmless since the pointers restart
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Packer, FIFO bookkeeping, drain FSM and registered status
    always_comb begin
        state_d      = state_q;
        op_cnt_d     = op_cnt_q;
        low_d        = low_q;
        have_low_d   = have_low_q;
        flush_pend_d = flush_pend_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_d       = fill_q;
        addr_ptr_d   = addr_ptr_q;
        word_count_d = word_count_q;
        wr_req_d     = wr_req_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = busy_q;
        byte_ready_d = byte_ready_q;
        push         = 1'b0;
        pop          = 1'b0;
        push_data    = '0;

        fifo_full = (fill_q == FILL_W'(FIFO_DEPTH));
        byte_acc  = byte_valid_i && byte_ready_q;

        if (byte_acc) begin
            if (have_low_q) begin
                push       = 1'b1;
                push_data  = {byte_in_i, low_q};
                have_low_d = 1'b0;
            end else begin
                low_d      = byte_in_i;
                have_low_d = 1'b1;
            end
        end

        // Byte ready is held low while flushing, so the pad push never collides with a byte push
        if (flush_pend_q) begin
            if (!fifo_full) begin
                push         = 1'b1;
                push_data    = {PAD_BYTE, low_q};
                have_low_d   = 1'b0;
                flush_pend_d = 1'b0;
            end
        end else if (flush_i && have_low_d) begin
            flush_pend_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (fill_q != '0) begin
                    pop       = 1'b1;
                    wr_data_d = mem_q[rd_ptr_q];
                    wr_addr_d = addr_ptr_q;
                    wr_req_d  = 1'b1;
                    op_cnt_d  = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                op_cnt_d = op_cnt_q + CNT_W'(1);
                if (op_cnt_q == CNT_W'(REQ_HOLD - 1)) begin
                    wr_req_d = 1'b0;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                op_cnt_d = op_cnt_q + CNT_W'(1);
                if (op_cnt_q == CNT_W'(OP_CYCLES - 1)) begin
                    addr_ptr_d   = addr_ptr_q + ADDR_W'(1);
                    word_count_d = word_count_q + ADDR_W'(1);
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // START only lands while idle, so it never races the pointer increment above
        if (start_i && !busy_q) begin
            addr_ptr_d   = base_addr_i;
            word_count_d = '0;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            fill_d = fill_q + FILL_W'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - FILL_W'(1);
        end

        busy_d       = have_low_d || (fill_d != '0) || (state_d != ST_IDLE);
        byte_ready_d = !(have_low_d && (fill_d == FILL_W'(FIFO_DEPTH))) && !flush_pend_d;
    end

endmodule

// File: tb/tb_sdram_byte_writer.sv
// Directed bench for sdram_byte_writer: packing, pacing, flush, address wrap, reset and START.
module tb_sdram_byte_writer;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [21:0] base_addr_i;
    logic [7:0]  byte_in_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        flush_i;
    logic        wr_req_o;
    logic [21:0] wr_addr_o;
    logic [15:0] wr_data_o;
    logic        busy_o;
    logic [21:0] word_count_o;

    int n_checks = 0;
    int n_err    = 0;
    bit saw_stall;

    logic [21:0] mon_addr[$];
    logic [15:0] mon_data[$];
    logic        req_prev = 1'b0;

    sdram_byte_writer dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .byte_in_i    (byte_in_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .flush_i      (flush_i),
        .wr_req_o     (wr_req_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .word_count_o (word_count_o)
    );

    always #5 clk = ~clk;

    // Record every write at its first WR_REQ cycle
    always @(negedge clk) begin
        if (wr_req_o && !req_prev) begin
            mon_addr.push_back(wr_addr_o);
            mon_data.push_back(wr_data_o);
        end
        req_prev <= wr_req_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic rdy;
        n = 0;
        byte_in_i    = b;
        byte_valid_i = 1'b1;
        do begin
            rdy = byte_ready_o;
            if (!rdy) saw_stall = 1'b1;
            tick();
            n++;
        end while (!rdy && n < 200);
        check("byte_accept", 32'(rdy), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (busy_o && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, 32'(busy_o), 32'd0);
    endtask

    task automatic do_start(input logic [21:0] base);
        start_i     = 1'b1;
        base_addr_i = base;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
    endtask

    initial begin
        logic [7:0]  b;
        logic [21:0] a0;
        logic [15:0] d0;
        bit          req_ok;
        bit          stable_ok;
        int          nw;

        reset_i = 1'b1; start_i = 1'b0; base_addr_i = '0;
        byte_in_i = '0; byte_valid_i = 1'b0; flush_i = 1'b0;
        saw_stall = 1'b0;
        repeat (3) tick();
        check("rst_wr_req", 32'(wr_req_o), 32'd0);
        check("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        check("rst_wr_data", 32'(wr_data_o), 32'd0);
        check("rst_word_count", 32'(word_count_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ready", 32'(byte_ready_o), 32'd1);
        reset_i = 1'b0;
        tick();

        // 1: single word, exact pacing
        clear_mon();
        do_start(22'h000100);
        send_byte(8'h34);
        send_byte(8'h12);
        byte_valid_i = 1'b0;
        check("t1_req_after_push", 32'(wr_req_o), 32'd0);
        check("t1_busy", 32'(busy_o), 32'd1);
        tick();
        check("t1_req_rise", 32'(wr_req_o), 32'd1);
        check("t1_addr", 32'(wr_addr_o), 32'h000100);
        check("t1_data", 32'(wr_data_o), 32'h1234);
        req_ok = 1'b1;
        stable_ok = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (wr_req_o !== (k == 1)) req_ok = 1'b0;
            if (wr_addr_o !== 22'h000100 || wr_data_o !== 16'h1234) stable_ok = 1'b0;
            if (k == 9) begin
                check("t1_busy_last_hold", 32'(busy_o), 32'd1);
                check("t1_wc_before_exit", 32'(word_count_o), 32'd0);
            end
        end
        check("t1_req_two_cycles", 32'(req_ok), 32'd1);
        check("t1_stable", 32'(stable_ok), 32'd1);
        check("t1_word_count", 32'(word_count_o), 32'd1);
        check("t1_busy_fall", 32'(busy_o), 32'd0);
        check("t1_nwrites", 32'(mon_addr.size()), 32'd1);

        // 2: 12-byte burst with backpressure
        clear_mon();
        saw_stall = 1'b0;
        do_start(22'h000200);
        for (int i = 0; i < 12; i++) begin
            b = 8'h10 + 8'(i);
            send_byte(b);
        end
        byte_valid_i = 1'b0;
        wait_idle("t2_idle", 300);
        check("t2_stall_seen", 32'(saw_stall), 32'd1);
        check("t2_nwrites", 32'(mon_addr.size()), 32'd6);
        check("t2_word_count", 32'(word_count_o), 32'd6);
        nw = (mon_addr.size() < 6) ? mon_addr.size() : 6;
        for (int j = 0; j < nw; j++) begin
            a0 = 22'h000200 + 22'(j);
            d0 = {8'h11 + 8'(2 * j), 8'h10 + 8'(2 * j)};
            check($sformatf("t2_addr%0d", j), 32'(mon_addr[j]), 32'(a0));
            check($sformatf("t2_data%0d", j), 32'(mon_data[j]), 32'(d0));
        end

        // 3: odd byte flushed with pad, then a flush with nothing pending
        clear_mon();
        do_start(22'h000300);
        send_byte(8'hAB);
        byte_valid_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        wait_idle("t3_idle", 100);
        check("t3_nwrites", 32'(mon_addr.size()), 32'd1);
        if (mon_addr.size() > 0) begin
            check("t3_addr", 32'(mon_addr[0]), 32'h000300);
            check("t3_data", 32'(mon_data[0]), 32'hFFAB);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("t3_noop_busy", 32'(busy_o), 32'd0);
        repeat (15) tick();
        check("t3_noop_nwrites", 32'(mon_addr.size()), 32'd1);

        // 4: address wrap
        clear_mon();
        do_start(22'h3FFFFF);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        byte_valid_i = 1'b0;
        wait_idle("t4_idle", 100);
        check("t4_nwrites", 32'(mon_addr.size()), 32'd2);
        if (mon_addr.size() == 2) begin
            check("t4_addr0", 32'(mon_addr[0]), 32'h3FFFFF);
            check("t4_data0", 32'(mon_data[0]), 32'h0201);
            check("t4_addr1", 32'(mon_addr[1]), 32'h000000);
            check("t4_data1", 32'(mon_data[1]), 32'h0403);
        end
        check("t4_word_count", 32'(word_count_o), 32'd2);

        // 5: reset during HOLD with two words queued
        clear_mon();
        do_start(22'h000500);
        for (int i = 0; i < 6; i++) begin
            b = 8'h50 + 8'(i);
            send_byte(b);
        end
        byte_valid_i = 1'b0;
        repeat (2) tick();
        check("t5_pre_req", 32'(wr_req_o), 32'd0);
        check("t5_pre_busy", 32'(busy_o), 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("t5_req", 32'(wr_req_o), 32'd0);
        check("t5_busy", 32'(busy_o), 32'd0);
        check("t5_addr", 32'(wr_addr_o), 32'd0);
        check("t5_data", 32'(wr_data_o), 32'd0);
        check("t5_word_count", 32'(word_count_o), 32'd0);
        check("t5_ready", 32'(byte_ready_o), 32'd1);
        repeat (40) tick();
        check("t5_nwrites", 32'(mon_addr.size()), 32'd1);
        check("t5_busy_later", 32'(busy_o), 32'd0);

        // 6: START while busy is ignored
        clear_mon();
        do_start(22'h000600);
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        send_byte(8'hC4);
        byte_valid_i = 1'b0;
        check("t6_busy_at_start", 32'(busy_o), 32'd1);
        do_start(22'h000700);
        wait_idle("t6_idle", 100);
        check("t6_nwrites", 32'(mon_addr.size()), 32'd2);
        if (mon_addr.size() == 2) begin
            check("t6_addr0", 32'(mon_addr[0]), 32'h000600);
            check("t6_data0", 32'(mon_data[0]), 32'hC2C1);
            check("t6_addr1", 32'(mon_addr[1]), 32'h000601);
            check("t6_data1", 32'(mon_data[1]), 32'hC4C3);
        end
        check("t6_word_count", 32'(word_count_o), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
